// File: rtl/param_sync_fifo.sv
// ----------------------------------------------------------------------------
// param_sync_fifo
//
// Purpose:
//   Single-clock valid/ready FIFO with configurable data width, depth and
//   almost-full threshold. It reports its occupancy and keeps a sticky flag
//   for attempted writes while full. The head entry is shown ahead on
//   out_data. Read and write paths do not bypass each other within a cycle.
//
// Parameters:
//   WIDTH       - data width in bits (>= 1)
//   DEPTH       - number of entries (power of two, >= 2)
//   AFULL_LEVEL - occupancy at or above which almost_full asserts (1..DEPTH)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   producer offers in_data
//   in_ready     out  FIFO can accept a word (not full)
//   in_data      in   write data, WIDTH bits
//   out_valid    out  head entry is valid (not empty)
//   out_ready    in   consumer takes the head entry
//   out_data     out  head entry, WIDTH bits
//   level        out  current occupancy 0..DEPTH, AW+1 bits
//   almost_full  out  level >= AFULL_LEVEL
//   overflow     out  sticky, set by a write attempt while full
// ----------------------------------------------------------------------------
module param_sync_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow
);

    // Pointer index width; derived only, never set from outside.
    localparam int AW = $clog2(DEPTH);

    // Constants sized to the pointer width so comparisons stay width-exact.
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_L = (AW+1)'(AFULL_LEVEL);

    // Reject illegal configurations while elaborating.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
        $error("param_sync_fifo: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_badAfull
        $error("param_sync_fifo: AFULL_LEVEL=%0d must be in 1..DEPTH", AFULL_LEVEL);
    end
    if (WIDTH < 1) begin : g_badWidth
        $error("param_sync_fifo: WIDTH=%0d must be >= 1", WIDTH);
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_level;

    // The extra MSB on each pointer separates "same slot, no lap" (empty)
    // from "same slot, one lap ahead" (full).
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                     (r_wrPtr[AW] != r_rdPtr[AW]);

    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;

    // Modular subtraction gives the occupancy directly, even across a wrap.
    assign w_level = r_wrPtr - r_rdPtr;

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign out_data    = r_mem[r_rdPtr[AW-1:0]];
    assign level       = w_level;
    assign almost_full = (w_level >= AFULL_L);
    assign overflow    = r_overflow;

    // Storage array has no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= in_data;
        end
    end

    // Pointers wrap naturally at 2^(AW+1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Overflow latches any rejected write and only a reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Consistency checks; none of these can trigger unless the logic is broken.
    a_noPushWhenFull : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full));
    a_noPopWhenEmpty : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && w_empty));
    a_levelInRange   : assert property (@(posedge clk) disable iff (!rst_n)
        (w_level <= DEPTH_L));

endmodule

// File: tb/tb_param_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Purpose:
//   Self-checking bench for param_sync_fifo. The main instance uses the
//   default parameters and is checked by a scoreboard: the driver pushes
//   expected words into a queue and tracks occupancy with a plain counter.
//   A separate monitor compares status outputs every cycle and pops and
//   compares data whenever the DUT hands a word to the consumer. A second
//   instance (WIDTH=16, DEPTH=8, AFULL_LEVEL=6) is walked up to full and
//   back down to check the threshold and the full boundary.
// ----------------------------------------------------------------------------
module tb_param_sync_fifo;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic        almost_full;
    logic        overflow;

    logic        in8Valid;
    logic        in8Ready;
    logic [15:0] in8Data;
    logic        out8Valid;
    logic        out8Ready;
    logic [15:0] out8Data;
    logic [3:0]  level8;
    logic        afull8;
    logic        ovf8;

    int          checks = 0;
    int          errors = 0;

    // Reference model: queue of words the FIFO should hold, plus counters.
    logic [7:0]  expQ [$];
    int          modelLevel = 0;
    bit          modelOvf = 1'b0;

    // Status expected for the current cycle, captured before the next edge.
    int          expLevel = 0;
    bit          expReady = 1'b1;
    bit          expValid = 1'b0;
    bit          expAfull = 1'b0;
    bit          expOvf = 1'b0;
    bit          checkEn = 1'b0;
    logic [7:0]  expHead;

    always #5 clk = ~clk;

    param_sync_fifo u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    param_sync_fifo #(
        .WIDTH       (16),
        .DEPTH       (8),
        .AFULL_LEVEL (6)
    ) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in8Valid),
        .in_ready    (in8Ready),
        .in_data     (in8Data),
        .out_valid   (out8Valid),
        .out_ready   (out8Ready),
        .out_data    (out8Data),
        .level       (level8),
        .almost_full (afull8),
        .overflow    (ovf8)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of stimulus at the falling edge and advances the model
    // by what the FIFO should do on the following rising edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
        bit accept;
        bit take;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        expLevel  = modelLevel;
        expReady  = (modelLevel < DEPTH);
        expValid  = (modelLevel > 0);
        expAfull  = (modelLevel >= AFULL);
        expOvf    = modelOvf;
        accept    = v && (modelLevel < DEPTH);
        take      = r && (modelLevel > 0);
        if (v && !accept) begin
            modelOvf = 1'b1;
        end
        if (accept) begin
            expQ.push_back(d);
        end
        modelLevel = modelLevel + (accept ? 1 : 0) - (take ? 1 : 0);
    endtask

    // Asserts reset between clock edges and checks that outputs clear at once.
    task automatic asyncReset();
        @(posedge clk);
        #2;
        checkEn   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", out_valid, 0);
        checkOutput("async_rst_level", level, 0);
        checkOutput("async_rst_overflow", overflow, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        checkOutput("async_rst_almost_full", almost_full, 0);
        expQ.delete();
        modelLevel = 0;
        modelOvf   = 1'b0;
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        checkEn = 1'b1;
    endtask

    // Monitor: compares status every cycle and data on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (checkEn) begin
                checkOutput("level", level, expLevel);
                checkOutput("in_ready", in_ready, expReady);
                checkOutput("out_valid", out_valid, expValid);
                checkOutput("almost_full", almost_full, expAfull);
                checkOutput("overflow", overflow, expOvf);
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_pop actual=0x%0h expected=none", out_data);
                    end else begin
                        expHead = expQ.pop_front();
                        checkOutput("out_data", out_data, expHead);
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        in8Valid  = 1'b0;
        in8Data   = '0;
        out8Ready = 1'b0;

        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_level", level, 0);
        checkOutput("reset_almost_full", almost_full, 0);
        checkOutput("reset_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n   = 1'b1;
        checkEn = 1'b1;

        // Three pushes with the consumer stalled, then drain.
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        checkOutput("t1_level", level, 3);
        checkOutput("t1_almost_full", almost_full, 1);
        checkOutput("t1_head", out_data, 8'h11);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        checkOutput("t1_drained_level", level, 0);
        checkOutput("t1_drained_valid", out_valid, 0);

        // Fill, then write while full with the consumer ready.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
        end
        applyStimulus(1'b1, 8'h55, 1'b1);
        #2;
        checkOutput("t2_full_in_ready", in_ready, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        checkOutput("t2_after_pop_in_ready", in_ready, 1);
        checkOutput("t2_overflow_sticky", overflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Level is 2 here; reset in the middle of the burst.
        asyncReset();
        applyStimulus(1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Continuous stream, wraps the pointers several times.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
        end
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b1);

        // Random traffic with varying producer/consumer pressure.
        for (int i = 0; i < 400; i++) begin
            int pv;
            int pr;
            pv = (i < 200) ? 70 : 35;
            pr = (i < 200) ? 35 : 70;
            applyStimulus($urandom_range(0, 99) < pv, 8'($urandom),
                          $urandom_range(0, 99) < pr);
        end
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Deeper instance: walk up to full, checking threshold at every level.
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            #2;
            checkOutput("d8_fill_level", level8, k);
            checkOutput("d8_fill_almost_full", afull8, (k >= 6) ? 1 : 0);
            checkOutput("d8_fill_in_ready", in8Ready, (k < 8) ? 1 : 0);
            in8Valid = (k < 8);
            in8Data  = 16'(16'hA000 + k);
        end
        in8Valid = 1'b0;
        // Walk back down, checking order and the falling threshold.
        for (int j = 0; j <= 8; j++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            #2;
            checkOutput("d8_drain_level", level8, 8 - j);
            checkOutput("d8_drain_almost_full", afull8, ((8 - j) >= 6) ? 1 : 0);
            checkOutput("d8_drain_out_valid", out8Valid, (j < 8) ? 1 : 0);
            if (j < 8) begin
                checkOutput("d8_drain_data", out8Data, 16'hA000 + j);
            end
            out8Ready = (j < 8);
        end
        out8Ready = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        #2;
        checkOutput("d8_overflow_clear", ovf8, 0);
        checkOutput("d8_empty_level", level8, 0);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
